// File: rtl/decoder_pkg.sv
// decoder_pkg
// Shared definitions for the pipelined one-hot decoder slice.
//   state_t / ST_IDLE / ST_DRIVE : FSM state encoding (IDLE=0, DRIVE=1)
//   clog2()                      : ceiling log2 usable in constant expressions
//   onehot_width_ok()            : legality check for code width vs. output count
package decoder_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_DRIVE = 1'b1;

  // Ceiling log2 with clog2(1) = 0, kept local so elaboration does not
  // depend on the tool's own $clog2 corner-case behaviour.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // A code of in_w bits can address at most 2**in_w select lines, and at
  // least two lines are needed for the decoder to mean anything.
  function automatic bit onehot_width_ok(input int in_w, input int n);
    return (in_w >= 1) && (in_w <= 12) && (n >= 2) && (n <= (1 << in_w));
  endfunction

endpackage

// File: rtl/decoder_onehot_pipe_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high clear
//   inc   : count one event on this edge
//   count : current value
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Increment on request unless already saturated; the clear is immediate
  // so the count is zero while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/decoder_onehot_pipe.sv
// decoder_onehot_pipe
// Registered binary-to-one-hot decoder with a valid/ready request side and
// two drive modes: a fixed-length strobe (pulse) or a level held until the
// consumer acknowledges it.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : request present
//   in_ready    : decoder idle and able to take a request
//   in_code     : binary select code, sampled only when accepted
//   in_level    : 1 = hold until out_ack, 0 = strobe for PULSE_CYCLES
//   out_onehot  : registered select lines, zero or exactly one-hot
//   out_valid   : OR of out_onehot
//   out_ack     : consumer acknowledge, meaningful in level mode only
//   err_oor     : one-cycle flag for an accepted out-of-range code
//   err_count   : saturating count of out-of-range requests
//   txn_count   : saturating count of accepted in-range requests, present
//                 only when DECODER_ONEHOT_PIPE_STATS_EN is defined
module decoder_onehot_pipe
  import decoder_pkg::*;
#(
  parameter int IN_WIDTH     = 5,
  parameter int NUM_OUTPUTS  = 32,
  parameter int PULSE_CYCLES = 1,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_code,
  input  logic                   in_level,
  output logic [NUM_OUTPUTS-1:0] out_onehot,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic                   err_oor,
`ifdef DECODER_ONEHOT_PIPE_STATS_EN
  output logic [15:0]            txn_count,
`endif
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int CNT_W = (clog2(PULSE_CYCLES) > 0) ? clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [NUM_OUTPUTS-1:0] ONE_HOT_LSB = {{(NUM_OUTPUTS-1){1'b0}}, 1'b1};

  // Reject illegal configurations at elaboration instead of building a
  // decoder whose codes cannot reach every line.
  if (!onehot_width_ok(IN_WIDTH, NUM_OUTPUTS) || (PULSE_CYCLES < 1) || (ERR_CNT_W < 1)) begin : g_param_check
    $error("decoder_onehot_pipe: illegal IN_WIDTH/NUM_OUTPUTS/PULSE_CYCLES/ERR_CNT_W");
  end

  state_t           state_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             code_in_range;
  logic             accept;
  logic             bad_req;
  logic             drive_done;

  // The code is zero-extended to 32 bits so NUM_OUTPUTS == 2**IN_WIDTH
  // compares correctly without overflowing the code width.
  assign code_in_range = ({{(32-IN_WIDTH){1'b0}}, in_code} < 32'(NUM_OUTPUTS));
  assign in_ready      = (state_q == ST_IDLE);
  assign accept        = in_ready && in_valid && code_in_range;
  assign bad_req       = in_ready && in_valid && !code_in_range;
  assign drive_done    = level_q ? out_ack : (cnt_q == '0);
  assign out_valid     = |out_onehot;

  // Main FSM. IDLE takes one request; DRIVE holds the select line until the
  // strobe counter expires or the consumer acknowledges, then always spends
  // one cycle back in IDLE before the next request can be taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_onehot <= '0;
      level_q    <= 1'b0;
      cnt_q      <= '0;
      err_oor    <= 1'b0;
    end else begin
      err_oor <= bad_req;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            out_onehot <= ONE_HOT_LSB << in_code;
            level_q    <= in_level;
            cnt_q      <= CNT_LOAD;
            state_q    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (drive_done) begin
            out_onehot <= '0;
            state_q    <= ST_IDLE;
          end else if (!level_q) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          out_onehot <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  // Out-of-range requests are counted on the same edge that raises err_oor.
  sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (bad_req),
    .count (err_count)
  );

`ifdef DECODER_ONEHOT_PIPE_STATS_EN
  // Accepted in-range requests, counted on the accepting edge.
  sat_counter #(
    .WIDTH (16)
  ) u_txn_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (txn_count)
  );
`endif

endmodule

// File: tb/tb_decoder_onehot_pipe.sv
// tb_decoder_onehot_pipe
// Directed bench for decoder_onehot_pipe (IN_WIDTH=5, NUM_OUTPUTS=20,
// PULSE_CYCLES=3, ERR_CNT_W=2). Expected select patterns are queued when a
// request is driven and compared when out_valid rises.
module tb_decoder_onehot_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_code;
  logic        in_level;
  logic [19:0] out_onehot;
  logic        out_valid;
  logic        out_ack;
  logic        err_oor;
  logic [1:0]  err_count;
`ifdef DECODER_ONEHOT_PIPE_STATS_EN
  logic [15:0] txn_count;
`endif

  int          pass_count;
  int          fail_count;
  int          check_count;
  int          exp_txn;
  logic        prev_valid;
  logic [19:0] exp_q[$];

  decoder_onehot_pipe #(
    .IN_WIDTH     (5),
    .NUM_OUTPUTS  (20),
    .PULSE_CYCLES (3),
    .ERR_CNT_W    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_level   (in_level),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .err_oor    (err_oor),
`ifdef DECODER_ONEHOT_PIPE_STATS_EN
    .txn_count  (txn_count),
`endif
    .err_count  (err_count)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) begin
      pass_count++;
    end else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request; in-range codes queue their expected select pattern.
  task automatic applyStimulus(input logic valid, input logic [4:0] code, input logic level);
    logic [19:0] one;
    in_valid = valid;
    in_code  = code;
    in_level = level;
    if (valid && (code < 5'd20)) begin
      one = 20'h1;
      exp_q.push_back(one << code);
      exp_txn++;
    end
  endtask

  // Advance one edge and sample 1 time unit later; a rising out_valid
  // retires the oldest queued expectation.
  task automatic tick();
    logic [19:0] expv;
    @(posedge clk);
    #1;
    if (out_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_count++;
        fail_count++;
        $error("[TB] FAIL sb_unexpected observed=0x%0h expected=no output", out_onehot);
      end else begin
        expv = exp_q.pop_front();
        checkOutput("sb_onehot", 32'(out_onehot), 32'(expv));
      end
    end
    prev_valid = out_valid;
  endtask

  initial begin
    pass_count  = 0;
    fail_count  = 0;
    check_count = 0;
    exp_txn     = 0;
    prev_valid  = 1'b0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_code     = '0;
    in_level    = 1'b0;
    out_ack     = 1'b0;

    #12;
    checkOutput("rst_onehot", 32'(out_onehot), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_err_oor", 32'(err_oor), 32'h0);
    checkOutput("rst_err_count", 32'(err_count), 32'h0);
    #10;
    rst = 1'b0;
    checkOutput("rst_ready", 32'(in_ready), 32'h1);

    // Reset asserted mid-DRIVE clears the output before any edge.
    tick();
    applyStimulus(1'b1, 5'd7, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("mid_drive_onehot", 32'(out_onehot), 32'h80);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_onehot", 32'(out_onehot), 32'h0);
    checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
    #2 rst = 1'b0;
    prev_valid = 1'b0;
    exp_txn    = 0;
    checkOutput("post_rst_ready", 32'(in_ready), 32'h1);

    // Pulse mode: three cycles high, ready back on the fourth.
    tick();
    applyStimulus(1'b1, 5'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("pulse_c1_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("pulse_c2", 32'(out_onehot), 32'h4);
    checkOutput("pulse_c2_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("pulse_c3", 32'(out_onehot), 32'h4);
    checkOutput("pulse_c3_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("pulse_end", 32'(out_onehot), 32'h0);
    checkOutput("pulse_end_ready", 32'(in_ready), 32'h1);

    // Level mode: held for ten cycles without ack, cleared after ack.
    applyStimulus(1'b1, 5'd19, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("level_hold", 32'(out_onehot), 32'h80000);
      if (i < 9) tick();
    end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    checkOutput("level_ack_clear", 32'(out_onehot), 32'h0);
    checkOutput("level_ack_ready", 32'(in_ready), 32'h1);

    // Ack in IDLE does nothing; ack in the first DRIVE cycle is honoured.
    out_ack = 1'b1;
    tick();
    checkOutput("idle_ack_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b1, 5'd5, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("ack_first_held", 32'(out_onehot), 32'h20);
    tick();
    out_ack = 1'b0;
    checkOutput("ack_first_clear", 32'(out_onehot), 32'h0);

    // Out-of-range codes back to back, then saturation of the 2-bit count.
    applyStimulus(1'b1, 5'd20, 1'b0);
    tick();
    checkOutput("oor1_flag", 32'(err_oor), 32'h1);
    checkOutput("oor1_count", 32'(err_count), 32'h1);
    checkOutput("oor1_onehot", 32'(out_onehot), 32'h0);
    checkOutput("oor1_ready", 32'(in_ready), 32'h1);
    applyStimulus(1'b1, 5'd31, 1'b0);
    tick();
    checkOutput("oor2_flag", 32'(err_oor), 32'h1);
    checkOutput("oor2_count", 32'(err_count), 32'h2);
    applyStimulus(1'b1, 5'd25, 1'b0);
    tick();
    checkOutput("oor3_flag", 32'(err_oor), 32'h1);
    checkOutput("oor3_count", 32'(err_count), 32'h3);
    checkOutput("oor3_onehot", 32'(out_onehot), 32'h0);
    applyStimulus(1'b0, 5'd0, 1'b0);
    tick();
    checkOutput("oor_flag_drop", 32'(err_oor), 32'h0);
    applyStimulus(1'b1, 5'd30, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd21, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("oor_sat_count", 32'(err_count), 32'h3);

    // Backpressure: code 4 held during code 1's strobe is taken once, later.
    tick();
    applyStimulus(1'b1, 5'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd4, 1'b0);
    checkOutput("bp_first_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("bp_first_c2", 32'(out_onehot), 32'h2);
    tick();
    checkOutput("bp_first_c3", 32'(out_onehot), 32'h2);
    tick();
    checkOutput("bp_gap_onehot", 32'(out_onehot), 32'h0);
    checkOutput("bp_gap_ready", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    checkOutput("bp_second_c1", 32'(out_onehot), 32'h10);
    tick();
    tick();
    checkOutput("bp_second_c3", 32'(out_onehot), 32'h10);
    tick();
    checkOutput("bp_second_end", 32'(out_onehot), 32'h0);
    tick();
    tick();
    checkOutput("bp_no_dup", 32'(out_onehot), 32'h0);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);

`ifdef DECODER_ONEHOT_PIPE_STATS_EN
    checkOutput("txn_count", 32'(txn_count), 32'(exp_txn));
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
